// File: rtl/log_pkg.sv
// Shared types, constants and arithmetic helpers for the log-domain datapath.
// Word format: bit WIDTH-1 = sign (1 = positive), bits WIDTH-2:0 = two's-complement
// log2 magnitude with FRAC fractional bits. The most-negative magnitude code is ZERO.
// Optional build macro: LOG_DOT_SAT_EN (magnitude overflow saturates instead of wrapping).
package log_pkg;

  localparam int WIDTH    = 16;
  localparam int INT_BITS = 5;
  localparam int FRAC     = WIDTH - 1 - INT_BITS;
  localparam int CF_FRAC  = 2;
  localparam int CF_RANGE = 12;

  localparam int MAG_W    = WIDTH - 1;
  localparam int CF_N     = CF_RANGE << CF_FRAC;   // LUT entries covering 0 <= r < CF_RANGE
  localparam int CF_W     = FRAC + 2;              // wide enough for CF- at its clamped first entry
  localparam int CF_SHIFT = FRAC - CF_FRAC;        // r >> CF_SHIFT gives the LUT index
  localparam int IDX_W    = $clog2(CF_N);

  typedef logic signed [MAG_W-1:0] mag_t;

  typedef struct packed {
    logic sign;
    mag_t mag;
  } logword_t;

  localparam mag_t     MAG_ZERO = {1'b1, {(MAG_W-1){1'b0}}};
  localparam mag_t     MAG_MAX  = {1'b0, {(MAG_W-1){1'b1}}};
  localparam logword_t LOG_ZERO = {1'b0, MAG_ZERO};

  // Fixed-point helpers for building the correction tables at elaboration.
  // Values are Q30; logarithms come back with LB fractional bits before rounding.
  localparam int QB = 30;
  localparam int LB = 14;

  // 2^(-f/4) in Q30; the quarter-step table ties this builder to CF_FRAC = 2.
  function automatic longint pow2_frac(input int f);
    case (f)
      0:       return 64'd1073741824;
      1:       return 64'd902905651;
      2:       return 64'd759250125;
      default: return 64'd638450708;
    endcase
  endfunction

  // 2^(-idx / 2^CF_FRAC) in Q30
  function automatic longint pow2_neg(input int idx);
    return pow2_frac(idx & 3) >>> (idx >> CF_FRAC);
  endfunction

  // log2 of a positive Q30 value, result in signed Q(LB), by normalise-and-square
  function automatic longint log2_q(input longint v);
    longint m;
    longint e;
    longint y;
    m = v;
    e = 0;
    for (int i = 0; i < 64; i++) begin
      if (m >= (longint'(2) << QB)) begin
        m = m >>> 1;
        e = e + 1;
      end
    end
    for (int i = 0; i < 64; i++) begin
      if (m < (longint'(1) << QB)) begin
        m = m <<< 1;
        e = e - 1;
      end
    end
    y = 0;
    for (int i = 1; i <= LB; i++) begin
      m = (m * m) >>> QB;
      if (m >= (longint'(2) << QB)) begin
        m = m >>> 1;
        y = y | (longint'(1) << (LB - i));
      end
    end
    return (e <<< LB) + y;
  endfunction

  // CF+(r) = log2(1 + 2^-r), entry i sampled at r = i / 2^CF_FRAC, rounded to FRAC bits
  function automatic logic [CF_N*CF_W-1:0] build_cf_plus();
    logic [CF_N*CF_W-1:0] t;
    longint c;
    t = '0;
    for (int i = 0; i < CF_N; i++) begin
      c = log2_q((longint'(1) << QB) + pow2_neg(i));
      t[i*CF_W +: CF_W] = CF_W'((c + (longint'(1) << (LB - FRAC - 1))) >>> (LB - FRAC));
    end
    return t;
  endfunction

  // CF-(r) = -log2(1 - 2^-r); the r < 0.25 bin would be unbounded, so it reuses the r = 0.25 value
  function automatic logic [CF_N*CF_W-1:0] build_cf_minus();
    logic [CF_N*CF_W-1:0] t;
    longint c;
    int j;
    t = '0;
    for (int i = 0; i < CF_N; i++) begin
      j = (i == 0) ? 1 : i;
      c = -log2_q((longint'(1) << QB) - pow2_neg(j));
      t[i*CF_W +: CF_W] = CF_W'((c + (longint'(1) << (LB - FRAC - 1))) >>> (LB - FRAC));
    end
    return t;
  endfunction

  localparam logic [CF_N*CF_W-1:0] CF_PLUS_LUT  = build_cf_plus();
  localparam logic [CF_N*CF_W-1:0] CF_MINUS_LUT = build_cf_minus();

  function automatic logic is_zero(input logword_t w);
    return w.mag == MAG_ZERO;
  endfunction

  // Log-domain multiply: add magnitudes, XNOR signs, flush underflow to ZERO
  function automatic logword_t log_mul(input logword_t a, input logword_t b);
    logword_t r;
    logic signed [MAG_W:0] s;
    s = {a.mag[MAG_W-1], a.mag} + {b.mag[MAG_W-1], b.mag};
    r.sign = ~(a.sign ^ b.sign);
    r.mag  = s[MAG_W-1:0];
    if (is_zero(a) || is_zero(b)) begin
      r = LOG_ZERO;
    end else if (s <= $signed({1'b1, MAG_ZERO})) begin
      r = LOG_ZERO;
    end else if (s > $signed({1'b0, MAG_MAX})) begin
`ifdef LOG_DOT_SAT_EN
      r.mag = MAG_MAX;
`else
      r.mag = s[MAG_W-1:0];
`endif
    end
    return r;
  endfunction

endpackage

// File: rtl/log_add_cf.sv
// Combinational log-domain adder: picks the larger magnitude, looks up the
// CF+/CF- correction from r = |ma - mb|, and handles ZERO operands and exact
// cancellation. Optional build macro: LOG_DOT_SAT_EN (overflow saturates).
module log_add_cf
  import log_pkg::*;
(
  input  logword_t a,
  input  logword_t b,
  output logword_t y
);

  logic signed [MAG_W:0] diff;
  logic                  a_big;
  logic                  same;
  logword_t              big;
  logic [MAG_W:0]        r;
  logic [IDX_W-1:0]      idx;
  logic [CF_W-1:0]       corr;
  logic [MAG_W:0]        corr_ext;
  logic signed [MAG_W:0] sum;

  // Compare, correction lookup and result selection
  always_comb begin
    diff     = {a.mag[MAG_W-1], a.mag} - {b.mag[MAG_W-1], b.mag};
    a_big    = !diff[MAG_W];
    same     = (a.sign == b.sign);
    big      = a_big ? a : b;
    r        = a_big ? diff : -diff;
    idx      = '0;
    corr     = '0;
    if (r < (MAG_W+1)'(CF_RANGE << FRAC)) begin
      idx  = r[CF_SHIFT +: IDX_W];
      corr = same ? CF_PLUS_LUT[int'(idx)*CF_W +: CF_W] : CF_MINUS_LUT[int'(idx)*CF_W +: CF_W];
    end
    corr_ext = {{(MAG_W+1-CF_W){1'b0}}, corr};
    sum      = {big.mag[MAG_W-1], big.mag} + (same ? corr_ext : -corr_ext);

    y = big;
    if (is_zero(a) && is_zero(b)) begin
      y = LOG_ZERO;
    end else if (is_zero(a)) begin
      y = b;
    end else if (is_zero(b)) begin
      y = a;
    end else if (!same && (r == '0)) begin
      y = LOG_ZERO;
    end else if (sum > $signed({1'b0, MAG_MAX})) begin
`ifdef LOG_DOT_SAT_EN
      y.mag = MAG_MAX;
`else
      y.mag = sum[MAG_W-1:0];
`endif
    end else if (sum <= $signed({1'b1, MAG_ZERO})) begin
      y = LOG_ZERO;
    end else begin
      y.mag = sum[MAG_W-1:0];
    end
  end

endmodule

// File: rtl/log_dot_pipe.sv
// Pipelined log-domain dot product: Z log-multipliers, a registered log2(Z)-level
// adder tree, then an accumulator that emits one result per vector under
// valid/ready. One shared enable stalls every stage when the output is blocked.
// Optional build macro: LOG_DOT_SAT_EN (saturate instead of wrap on overflow).
module log_dot_pipe
  import log_pkg::*;
#(
  parameter int Z     = 4,
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_last,
  input  logic [WIDTH*Z-1:0] a_vec,
  input  logic [WIDTH*Z-1:0] b_vec,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data
);

  localparam int L    = $clog2(Z);
  localparam int N    = 2*Z - 1;   // leaves 0..Z-1, node Z+k has children 2k and 2k+1
  localparam int ROOT = 2*Z - 2;

  localparam logic [0:0] ST_FIRST = 1'b0;
  localparam logic [0:0] ST_ACCUM = 1'b1;

  logword_t   a_lane [Z];
  logword_t   b_lane [Z];
  logword_t   node_reg [N];
  logword_t   sum_w [Z-1];
  logic [L:0] valid_reg;
  logic [L:0] last_reg;

  logic [0:0] state_reg;
  logword_t   acc_reg;
  logword_t   acc_sum;
  logword_t   acc_in;
  logic       out_valid_reg;
  logword_t   out_data_reg;
  logic       en;

  assign en        = !(out_valid_reg && !out_ready);
  assign in_ready  = en;
  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;

  for (genvar gi = 0; gi < Z; gi++) begin : g_lane
    assign a_lane[gi] = a_vec[WIDTH*gi +: WIDTH];
    assign b_lane[gi] = b_vec[WIDTH*gi +: WIDTH];
  end

  for (genvar gi = 0; gi < Z-1; gi++) begin : g_tree
    log_add_cf u_add (
      .a (node_reg[2*gi]),
      .b (node_reg[2*gi+1]),
      .y (sum_w[gi])
    );
  end

  log_add_cf u_acc (
    .a (acc_reg),
    .b (node_reg[ROOT]),
    .y (acc_sum)
  );

  assign acc_in = (state_reg == ST_FIRST) ? node_reg[ROOT] : acc_sum;

  // Product and tree registers; valid/last bits shift alongside the data
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < N; k++) node_reg[k] <= LOG_ZERO;
      valid_reg <= '0;
      last_reg  <= '0;
    end else if (en) begin
      for (int k = 0; k < Z; k++)   node_reg[k]   <= log_mul(a_lane[k], b_lane[k]);
      for (int k = 0; k < Z-1; k++) node_reg[Z+k] <= sum_w[k];
      valid_reg <= {valid_reg[L-1:0], in_valid};
      last_reg  <= {last_reg[L-1:0], in_last};
    end
  end

  // Accumulator FSM and output register; a new result overwrites one being consumed
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= ST_FIRST;
      acc_reg       <= LOG_ZERO;
      out_valid_reg <= 1'b0;
      out_data_reg  <= LOG_ZERO;
    end else if (en) begin
      out_valid_reg <= valid_reg[L] && last_reg[L];
      if (valid_reg[L]) begin
        if (last_reg[L]) begin
          out_data_reg <= acc_in;
          acc_reg      <= LOG_ZERO;
          state_reg    <= ST_FIRST;
        end else begin
          acc_reg      <= acc_in;
          state_reg    <= ST_ACCUM;
        end
      end
    end
  end

endmodule

// File: tb/tb_log_dot_pipe.sv
// Directed bench for log_dot_pipe (Z=4, WIDTH=16). Inputs change and outputs
// are sampled on the falling edge; expected words are hand-derived constants.
module tb_log_dot_pipe;

  localparam int Z = 4;
  localparam int W = 16;
  localparam logic [W-1:0] ONE = 16'h8000;
  localparam logic [W-1:0] ZR  = 16'h4000;
`ifdef LOG_DOT_SAT_EN
  localparam logic [W-1:0] OVF_EXP = 16'hBFFF;   // clamped to max magnitude, sign kept
`else
  localparam logic [W-1:0] OVF_EXP = 16'hF800;   // 15.0 + 15.0 = 0x7800, read back as 15-bit code
`endif

  logic           clk = 1'b0;
  logic           reset;
  logic           in_valid;
  logic           in_ready;
  logic           in_last;
  logic [W*Z-1:0] a_vec;
  logic [W*Z-1:0] b_vec;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out_data;

  int checks = 0;
  int errors = 0;

  log_dot_pipe #(.Z(Z), .WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_last   (in_last),
    .a_vec     (a_vec),
    .b_vec     (b_vec),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
    $display("check %-16s observed %h expected %h", tag, obs, exp);
  endtask

  // Present one beat at a falling edge and hold it until accepted
  task automatic send_beat(input logic [W*Z-1:0] a, input logic [W*Z-1:0] b, input logic last);
    int n;
    n        = 0;
    in_valid = 1'b1;
    a_vec    = a;
    b_vec    = b;
    in_last  = last;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("beat_accept", 16'(in_ready), 16'd1);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Wait (bounded) for a result and compare it; it is consumed on the next edge
  task automatic expect_result(input string tag, input logic [W-1:0] exp);
    int n;
    n = 0;
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_vld"}, 16'(out_valid), 16'd1);
    check(tag, out_data, exp);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    a_vec     = {4{ZR}};
    b_vec     = {4{ZR}};
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst_out_valid", 16'(out_valid), 16'd0);
    check("rst_out_data", out_data, ZR);
    check("rst_in_ready", 16'(in_ready), 16'd1);

    // 1: four lanes of 1.0*1.0 -> 4.0, visible four cycles after acceptance
    send_beat({4{ONE}}, {4{ONE}}, 1'b1);
    check("lat_c1", 16'(out_valid), 16'd0);
    @(negedge clk);
    check("lat_c2", 16'(out_valid), 16'd0);
    @(negedge clk);
    check("lat_c3", 16'(out_valid), 16'd0);
    @(negedge clk);
    check("lat_c4", 16'(out_valid), 16'd1);
    check("ones_sum", out_data, 16'h8800);
    @(negedge clk);
    check("ones_popped", 16'(out_valid), 16'd0);

    // 2: three beats of 2*2 on lane 0 -> log2(12) = 3.585 -> mag 0xE57
    send_beat({ZR, ZR, ZR, 16'h8400}, {ZR, ZR, ZR, 16'h8400}, 1'b0);
    send_beat({ZR, ZR, ZR, 16'h8400}, {ZR, ZR, ZR, 16'h8400}, 1'b0);
    send_beat({ZR, ZR, ZR, 16'h8400}, {ZR, ZR, ZR, 16'h8400}, 1'b1);
    expect_result("accum_12", 16'h8E57);

    // 3: 1 - 1 + 2 - 2 cancels exactly to ZERO
    send_beat({16'h0400, 16'h8400, 16'h0000, ONE}, {4{ONE}}, 1'b1);
    expect_result("cancel", ZR);

    // 3b: 4 - 1 = 3 -> log2(3) = 1.585 -> mag 0x657 via CF-
    send_beat({ZR, ZR, 16'h0000, 16'h8800}, {ZR, ZR, ONE, ONE}, 1'b1);
    expect_result("diff_sign", 16'h8657);

    // Multiply underflow: (-15) + (-15) is below the smallest code -> ZERO
    send_beat({ZR, ZR, ZR, 16'hC400}, {ZR, ZR, ZR, 16'hC400}, 1'b1);
    expect_result("mul_underflow", ZR);

    // 4: multiply overflow 15.0 + 15.0
    send_beat({ZR, ZR, ZR, 16'hBC00}, {ZR, ZR, ZR, 16'hBC00}, 1'b1);
    expect_result("mul_overflow", OVF_EXP);

    // 5: back-pressure with four one-beat vectors 1*2^k
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      send_beat({ZR, ZR, ZR, ONE}, {ZR, ZR, ZR, 16'h8000 | 16'(k * 16'h0400)}, 1'b1);
    end
    begin
      int n;
      n = 0;
      while (!out_valid && n < 40) begin
        @(negedge clk);
        n++;
      end
    end
    check("stall_valid", 16'(out_valid), 16'd1);
    check("stall_in_ready", 16'(in_ready), 16'd0);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check($sformatf("stall_data_%0d", c), out_data, 16'h8000);
      check($sformatf("stall_rdy_%0d", c), 16'(in_ready), 16'd0);
    end
    out_ready = 1'b1;
    expect_result("drain_0", 16'h8000);
    expect_result("drain_1", 16'h8400);
    expect_result("drain_2", 16'h8800);
    expect_result("drain_3", 16'h8C00);
    check("drain_empty", 16'(out_valid), 16'd0);

    // 6: reset in the middle of a vector discards the partial sum
    send_beat({ZR, ZR, ZR, 16'h8400}, {ZR, ZR, ZR, 16'h8400}, 1'b0);
    send_beat({ZR, ZR, ZR, 16'h8400}, {ZR, ZR, ZR, 16'h8400}, 1'b0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("rst2_out_valid", 16'(out_valid), 16'd0);
    check("rst2_out_data", out_data, ZR);
    check("rst2_in_ready", 16'(in_ready), 16'd1);
    send_beat({4{ONE}}, {4{ONE}}, 1'b1);
    expect_result("post_reset", 16'h8800);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
